alarm_ring: RTL and testbench



---
 rtl/alarm_ring_if.sv | 30 +++
 rtl/alarm_ring.sv | 166 ++++++++++++++++
 tb/tb_alarm_ring.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ring_if.sv
// Alarm ringer port bundle: time/editor/button inputs toward the ringer, buzzer and status back.
// The master side owns time, alarm settings and the button; the slave side is alarm_ring.
interface alarm_ring_if;
    logic        tick_1hz;
    logic [10:0] hour;
    logic [10:0] minute;
    logic [10:0] second;
    logic [10:0] alarm_hour;
    logic [10:0] alarm_minute;
    logic        armed;
    logic [2:0]  alarm_mode;
    logic        middle;
    // Buzzer drive; "do" is a reserved word, so the line is called buzzer here.
    logic        buzzer;
    logic        ringing;
    logic        snoozing;
    logic [1:0]  snooze_cnt;

    modport master (
        output tick_1hz, hour, minute, second, alarm_hour, alarm_minute,
               armed, alarm_mode, middle,
        input  buzzer, ringing, snoozing, snooze_cnt
    );

    modport slave (
        input  tick_1hz, hour, minute, second, alarm_hour, alarm_minute,
               armed, alarm_mode, middle,
        output buzzer, ringing, snoozing, snooze_cnt
    );
endinterface

// File: rtl/alarm_ring.sv
// Alarm ringer: IDLE/RING/SNOOZE control with beep pattern, short-press snooze and long-hold dismiss.
// All outputs registered, one cycle after the deciding input; no backpressure, inputs sampled every cycle.
module alarm_ring #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int HOLD_SEC   = 2,
    parameter int MAX_SNOOZE = 3,
    parameter int BEEP_HALF  = 25000
) (
    input logic        newclk,
    input logic        rst_n,
    alarm_ring_if.slave bus
);

    localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);
    localparam int HOLD_W  = (HOLD_SEC > 1) ? $clog2(HOLD_SEC + 1) : 1;
    localparam int BEEP_W  = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              mid_q;
    logic              press_act;
    logic              buzz_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEC_W-1:0]  sec_cnt;
    logic [1:0]        snooze_q;
    logic [BEEP_W-1:0] beep_cnt;

    logic mid_rise;
    logic mid_fall;
    logic abort;
    logic match;
    logic hold_hit;
    logic ring_last;
    logic snooze_last;
    logic snooze_ok;
    logic enter_ring;
    logic enter_snooze;

    always_comb begin
        mid_rise     = bus.middle & ~mid_q;
        mid_fall     = ~bus.middle & mid_q;
        abort        = ~bus.armed | (bus.alarm_mode != 3'd0);
        match        = bus.tick_1hz
                     & (bus.hour == bus.alarm_hour)
                     & (bus.minute == bus.alarm_minute)
                     & (bus.second == 11'd0);
        hold_hit     = bus.tick_1hz & press_act & bus.middle
                     & (hold_cnt == HOLD_W'(HOLD_SEC - 1));
        ring_last    = bus.tick_1hz & (sec_cnt == SEC_W'(RING_SEC - 1));
        snooze_last  = bus.tick_1hz & (sec_cnt == SEC_W'(SNOOZE_SEC - 1));
        snooze_ok    = int'(snooze_q) < MAX_SNOOZE;
        state_nxt    = state;
        enter_ring   = 1'b0;
        enter_snooze = 1'b0;

        // Priority: abort, hold-dismiss, release-snooze, timeout / re-ring.
        case (state)
            ST_IDLE: begin
                if (!abort && match) begin
                    state_nxt  = ST_RING;
                    enter_ring = 1'b1;
                end
            end
            ST_RING: begin
                if (abort || hold_hit) begin
                    state_nxt = ST_IDLE;
                end else if (mid_fall && press_act) begin
                    if (snooze_ok) begin
                        state_nxt    = ST_SNOOZE;
                        enter_snooze = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (ring_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (abort || hold_hit) begin
                    state_nxt = ST_IDLE;
                end else if (snooze_last) begin
                    state_nxt  = ST_RING;
                    enter_ring = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mid_q     <= 1'b0;
            press_act <= 1'b0;
            buzz_q    <= 1'b0;
            hold_cnt  <= '0;
            sec_cnt   <= '0;
            snooze_q  <= 2'd0;
            beep_cnt  <= '0;
        end else begin
            mid_q <= bus.middle;
            state <= state_nxt;
            if (state_nxt == ST_IDLE) begin
                press_act <= 1'b0;
                buzz_q    <= 1'b0;
                hold_cnt  <= '0;
                sec_cnt   <= '0;
                snooze_q  <= 2'd0;
                beep_cnt  <= '0;
            end else if (enter_ring) begin
                // Re-ring from SNOOZE keeps the snooze count; a fresh alarm starts at zero.
                press_act <= 1'b0;
                buzz_q    <= 1'b1;
                hold_cnt  <= '0;
                sec_cnt   <= '0;
                beep_cnt  <= '0;
                if (state == ST_IDLE) begin
                    snooze_q <= 2'd0;
                end
            end else if (enter_snooze) begin
                press_act <= 1'b0;
                buzz_q    <= 1'b0;
                hold_cnt  <= '0;
                sec_cnt   <= '0;
                beep_cnt  <= '0;
                snooze_q  <= snooze_q + 2'd1;
            end else begin
                if (bus.tick_1hz) begin
                    sec_cnt <= sec_cnt + SEC_W'(1);
                end
                // A press only counts if its rising edge is seen while RING or SNOOZE is active.
                if (mid_fall) begin
                    press_act <= 1'b0;
                    hold_cnt  <= '0;
                end else begin
                    if (mid_rise) begin
                        press_act <= 1'b1;
                    end
                    if (bus.tick_1hz && press_act && bus.middle) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                if (state == ST_RING) begin
                    if (beep_cnt == BEEP_W'(BEEP_HALF - 1)) begin
                        beep_cnt <= '0;
                        buzz_q   <= ~buzz_q;
                    end else begin
                        beep_cnt <= beep_cnt + BEEP_W'(1);
                    end
                end
            end
        end
    end

    assign bus.buzzer     = buzz_q;
    assign bus.ringing    = (state == ST_RING);
    assign bus.snoozing   = (state == ST_SNOOZE);
    assign bus.snooze_cnt = snooze_q;

endmodule

// File: tb/tb_alarm_ring.sv
// Bench for alarm_ring: gating table, directed ring/snooze/hold/abort/reset sequences, random run vs model.
module tb_alarm_ring;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_SEC = 300;
    localparam int HOLD_SEC   = 2;
    localparam int MAX_SNOOZE = 3;
    localparam int BEEP_HALF  = 25000;
    localparam int T_ALARM    = 7 * 3600 + 30 * 60;

    logic newclk;
    logic rst_n;
    alarm_ring_if bus ();

    alarm_ring #(
        .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .HOLD_SEC(HOLD_SEC),
        .MAX_SNOOZE(MAX_SNOOZE), .BEEP_HALF(BEEP_HALF)
    ) dut (
        .newclk(newclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial newclk = 1'b0;
    always #5 newclk = ~newclk;

    int n_cmp = 0;
    int n_bad = 0;
    int sod;

    // Reference model: the alarm described as an event/phase record.
    bit m_ring, m_snooze, m_do, m_pressed, m_prev_mid;
    int m_secs, m_snoozes, m_hold, m_age;

    task automatic check(string nm, logic [7:0] got, logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ring = 0; m_snooze = 0; m_do = 0; m_pressed = 0; m_prev_mid = 0;
        m_secs = 0; m_snoozes = 0; m_hold = 0; m_age = 0;
    endtask

    task automatic model_idle();
        m_ring = 0; m_snooze = 0; m_do = 0; m_pressed = 0;
        m_secs = 0; m_snoozes = 0; m_hold = 0; m_age = 0;
    endtask

    task automatic model_start_ring(bit keep);
        m_ring = 1; m_snooze = 0; m_do = 1; m_pressed = 0;
        m_secs = 0; m_hold = 0; m_age = 0;
        if (!keep) m_snoozes = 0;
    endtask

    task automatic model_continue(bit tk, bit mid, bit rise, bit fall);
        if (tk) m_secs++;
        if (fall) begin
            m_pressed = 0;
            m_hold = 0;
        end else begin
            if (tk && m_pressed && mid) m_hold++;
            if (rise) m_pressed = 1;
        end
        if (m_ring) begin
            m_age++;
            m_do = ((m_age / BEEP_HALF) % 2) == 0;
        end
    endtask

    task automatic model_step();
        bit tk, mid, abort, rise, fall, hold_done, hit;
        tk = bus.tick_1hz;
        mid = bus.middle;
        abort = !bus.armed || (bus.alarm_mode != 3'd0);
        rise = mid && !m_prev_mid;
        fall = !mid && m_prev_mid;
        hold_done = tk && m_pressed && mid && (m_hold + 1 >= HOLD_SEC);
        hit = (bus.hour == bus.alarm_hour) && (bus.minute == bus.alarm_minute) && (bus.second == 11'd0);
        if (abort) model_idle();
        else if (!m_ring && !m_snooze) begin
            if (tk && hit) model_start_ring(0);
        end else if (m_ring) begin
            if (hold_done) model_idle();
            else if (fall && m_pressed) begin
                if (m_snoozes < MAX_SNOOZE) begin
                    m_snoozes++;
                    m_ring = 0; m_snooze = 1; m_do = 0;
                    m_secs = 0; m_hold = 0; m_pressed = 0; m_age = 0;
                end else model_idle();
            end else if (tk && m_secs + 1 >= RING_SEC) model_idle();
            else model_continue(tk, mid, rise, fall);
        end else begin
            if (hold_done) model_idle();
            else if (tk && m_secs + 1 >= SNOOZE_SEC) model_start_ring(1);
            else model_continue(tk, mid, rise, fall);
        end
        m_prev_mid = mid;
    endtask

    task automatic cyc();
        model_step();
        @(posedge newclk);
        #1;
        check("model r/s/cnt/do", {3'b0, bus.ringing, bus.snoozing, bus.snooze_cnt, bus.buzzer},
              {3'b0, m_ring, m_snooze, 2'(m_snoozes), m_do});
    endtask

    task automatic set_time();
        bus.hour   = 11'(sod / 3600);
        bus.minute = 11'((sod % 3600) / 60);
        bus.second = 11'(sod % 60);
    endtask

    task automatic ticks(int n, int gap);
        for (int i = 0; i < n; i++) begin
            sod = (sod + 1) % 86400;
            set_time();
            bus.tick_1hz = 1'b1;
            cyc();
            bus.tick_1hz = 1'b0;
            for (int j = 1; j < gap; j++) cyc();
        end
    endtask

    task automatic start_ring(string nm);
        sod = T_ALARM - 1;
        set_time();
        cyc();
        ticks(1, 1);
        check({nm, " ringing on match"}, 8'(bus.ringing), 8'd1);
    endtask

    task automatic snooze_press();
        bus.middle = 1'b1;
        cyc();
        bus.middle = 1'b0;
        cyc();
    endtask

    task automatic abort_pulse();
        bus.armed = 1'b0;
        cyc();
        bus.armed = 1'b1;
        cyc();
    endtask

    typedef struct {
        bit          tick;
        bit          armed;
        logic [2:0]  mode;
        logic [10:0] hour;
        logic [10:0] minute;
        logic [10:0] second;
        bit          exp_ring;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 1, 3'd0, 11'd7,    11'd30,  11'd0,    1};
        vecs[1]  = '{0, 1, 3'd0, 11'd7,    11'd30,  11'd0,    0};
        vecs[2]  = '{1, 0, 3'd0, 11'd7,    11'd30,  11'd0,    0};
        vecs[3]  = '{1, 1, 3'd1, 11'd7,    11'd30,  11'd0,    0};
        vecs[4]  = '{1, 1, 3'd4, 11'd7,    11'd30,  11'd0,    0};
        vecs[5]  = '{1, 1, 3'd0, 11'd7,    11'd30,  11'd1,    0};
        vecs[6]  = '{1, 1, 3'd0, 11'd7,    11'd31,  11'd0,    0};
        vecs[7]  = '{1, 1, 3'd0, 11'd8,    11'd30,  11'd0,    0};
        vecs[8]  = '{1, 1, 3'd0, 11'd1031, 11'd30,  11'd0,    0};
        vecs[9]  = '{1, 1, 3'd0, 11'd7,    11'd542, 11'd0,    0};
        vecs[10] = '{1, 1, 3'd0, 11'd7,    11'd30,  11'd1024, 0};
        vecs[11] = '{1, 1, 3'd0, 11'd7,    11'd30,  11'd0,    1};

        rst_n = 1'b0;
        bus.tick_1hz = 1'b0;
        bus.alarm_hour = 11'd7;
        bus.alarm_minute = 11'd30;
        bus.armed = 1'b1;
        bus.alarm_mode = 3'd0;
        bus.middle = 1'b0;
        sod = T_ALARM - 2;
        set_time();
        model_reset();
        repeat (3) @(posedge newclk);
        #1;
        check("reset ringing", 8'(bus.ringing), 8'd0);
        check("reset snoozing", 8'(bus.snoozing), 8'd0);
        check("reset snooze_cnt", 8'(bus.snooze_cnt), 8'd0);
        check("reset do", 8'(bus.buzzer), 8'd0);
        rst_n = 1'b1;
        cyc();

        // Matched time, beep toggle and 60-tick timeout
        ticks(1, 1);
        check("07:29:59 no ring", 8'(bus.ringing), 8'd0);
        ticks(1, 1);
        check("07:30:00 ringing", 8'(bus.ringing), 8'd1);
        check("07:30:00 do", 8'(bus.buzzer), 8'd1);
        for (int i = 0; i < BEEP_HALF - 1; i++) cyc();
        check("do before toggle", 8'(bus.buzzer), 8'd1);
        cyc();
        check("do first toggle", 8'(bus.buzzer), 8'd0);
        ticks(59, 2);
        check("ringing at 59 ticks", 8'(bus.ringing), 8'd1);
        ticks(1, 1);
        check("timeout ringing", 8'(bus.ringing), 8'd0);
        check("timeout do", 8'(bus.buzzer), 8'd0);
        check("timeout snooze_cnt", 8'(bus.snooze_cnt), 8'd0);

        // Gating table applied from IDLE
        for (int v = 0; v < 12; v++) begin
            bus.tick_1hz = vecs[v].tick;
            bus.armed = vecs[v].armed;
            bus.alarm_mode = vecs[v].mode;
            bus.hour = vecs[v].hour;
            bus.minute = vecs[v].minute;
            bus.second = vecs[v].second;
            cyc();
            check($sformatf("table[%0d] ringing", v), 8'(bus.ringing), 8'(vecs[v].exp_ring));
            check($sformatf("table[%0d] do", v), 8'(bus.buzzer), 8'(vecs[v].exp_ring));
            bus.tick_1hz = 1'b0;
            bus.alarm_mode = 3'd0;
            abort_pulse();
        end

        // Snooze cycle and snooze limit
        start_ring("snooze");
        bus.middle = 1'b1;
        cyc();
        ticks(1, 1);
        bus.middle = 1'b0;
        cyc();
        check("snooze entry snoozing", 8'(bus.snoozing), 8'd1);
        check("snooze entry cnt", 8'(bus.snooze_cnt), 8'd1);
        check("snooze entry do", 8'(bus.buzzer), 8'd0);
        ticks(299, 2);
        check("snooze at 299", 8'(bus.snoozing), 8'd1);
        ticks(1, 1);
        check("re-ring ringing", 8'(bus.ringing), 8'd1);
        check("re-ring cnt kept", 8'(bus.snooze_cnt), 8'd1);
        snooze_press();
        ticks(300, 2);
        snooze_press();
        check("third snooze cnt", 8'(bus.snooze_cnt), 8'd3);
        ticks(300, 2);
        check("third re-ring", 8'(bus.ringing), 8'd1);
        snooze_press();
        check("limit ringing", 8'(bus.ringing), 8'd0);
        check("limit snoozing", 8'(bus.snoozing), 8'd0);
        check("limit cnt", 8'(bus.snooze_cnt), 8'd0);

        // Long hold in RING, then in SNOOZE
        start_ring("hold ring");
        bus.middle = 1'b1;
        cyc();
        ticks(1, 1);
        check("hold 1 tick ringing", 8'(bus.ringing), 8'd1);
        ticks(1, 1);
        check("hold dismiss ring", 8'(bus.ringing), 8'd0);
        bus.middle = 1'b0;
        cyc();
        check("release after hold", 8'({bus.ringing, bus.snoozing}), 8'd0);
        start_ring("hold snooze");
        snooze_press();
        check("hold snooze entry", 8'(bus.snoozing), 8'd1);
        bus.middle = 1'b1;
        cyc();
        ticks(1, 1);
        check("hold 1 tick snoozing", 8'(bus.snoozing), 8'd1);
        ticks(1, 1);
        check("hold dismiss snooze", 8'({bus.ringing, bus.snoozing, bus.snooze_cnt}), 8'd0);
        bus.middle = 1'b0;
        cyc();
        check("release after snooze hold", 8'({bus.ringing, bus.snoozing}), 8'd0);

        // Abort by editor activity
        start_ring("abort");
        bus.alarm_mode = 3'd1;
        cyc();
        check("abort ringing", 8'(bus.ringing), 8'd0);
        bus.alarm_mode = 3'd0;
        cyc();

        // Release coinciding with the 60th tick
        start_ring("release vs timeout");
        ticks(59, 2);
        bus.middle = 1'b1;
        cyc();
        bus.middle = 1'b0;
        sod = (sod + 1) % 86400;
        set_time();
        bus.tick_1hz = 1'b1;
        cyc();
        bus.tick_1hz = 1'b0;
        check("release wins snoozing", 8'(bus.snoozing), 8'd1);
        check("release wins cnt", 8'(bus.snooze_cnt), 8'd1);
        abort_pulse();
        check("abort clears cnt", 8'(bus.snooze_cnt), 8'd0);

        // Asynchronous reset mid-ring
        start_ring("reset");
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 8'({bus.buzzer, bus.ringing, bus.snoozing, bus.snooze_cnt}), 8'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        repeat (3) cyc();
        check("after reset idle", 8'(bus.ringing), 8'd0);
        start_ring("after reset");
        abort_pulse();

        // Randomized run against the model
        sod = T_ALARM - 5;
        for (int c = 0; c < 20000; c++) begin
            bus.tick_1hz = ($urandom_range(0, 2) == 0);
            if (bus.tick_1hz) sod = (sod + 1) % 86400;
            else if (!m_ring && !m_snooze && sod > T_ALARM + 10) sod = T_ALARM - 5;
            set_time();
            if (bus.middle) bus.middle = ($urandom_range(0, 7) != 0);
            else bus.middle = ($urandom_range(0, 59) == 0);
            bus.armed = ($urandom_range(0, 699) != 0);
            bus.alarm_mode = ($urandom_range(0, 699) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
